jhash_feed: RTL and testbench

JHASH_FEED -- requirements
Module: jhash_feed

---
 rtl/jhash_feed.sv | 96 +++++++++
 tb/tb_jhash_feed.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/jhash_feed.sv
// jhash_feed: packs a key word stream into 3-word jhash_core groups and returns the final hash.
module jhash_feed #(
  parameter int GUARD = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        in_ready,
  output logic [31:0] stream_data0,
  output logic [31:0] stream_data1,
  output logic [31:0] stream_data2,
  output logic        stream_valid,
  output logic        stream_done,
  output logic [1:0]  stream_left,
  input  logic        stream_ack,
  input  logic [31:0] hash_in,
  input  logic        hash_done_in,
  output logic        core_rst,
  output logic [31:0] out_hash,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int GW = GUARD < 1 ? 1 : $clog2(GUARD + 1);
  typedef enum logic [2:0] {CLR, COLLECT, FULL, FINAL, RESULT} state_t;
  state_t        state_q;
  logic          clr_q;
  logic [1:0]    cnt_q, left_q;
  logic [GW-1:0] guard_q;
  logic [31:0]   data_q [3];
  logic [31:0]   hash_q;
  // Outputs decode registered state only, so reset takes effect on them immediately.
  assign in_ready     = state_q == COLLECT;
  assign stream_valid = state_q == FULL || state_q == FINAL;
  assign stream_done  = state_q == FINAL && guard_q == '0;
  assign core_rst     = state_q == CLR;
  assign out_valid    = state_q == RESULT;
  assign out_hash     = hash_q;
  assign stream_left  = left_q;
  assign stream_data0 = data_q[0];
  assign stream_data1 = data_q[1];
  assign stream_data2 = data_q[2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR;
      clr_q   <= 1'b0;
      cnt_q   <= '0;
      left_q  <= '0;
      guard_q <= '0;
      data_q  <= '{default: '0};
      hash_q  <= '0;
    end else begin
      if (guard_q != '0) guard_q <= guard_q - 1'b1;
      case (state_q)
        CLR: begin
          clr_q  <= ~clr_q;
          cnt_q  <= '0;
          left_q <= '0;
          data_q <= '{default: '0};
          if (clr_q) state_q <= COLLECT;
        end
        COLLECT: if (in_valid) begin
          if (!in_empty) begin
            data_q[cnt_q] <= in_data;
            cnt_q         <= cnt_q + 2'd1;
          end
          if (in_last) begin
            left_q  <= in_empty ? cnt_q : cnt_q + 2'd1;
            state_q <= FINAL;
          end else if (!in_empty && cnt_q == 2'd2) begin
            left_q  <= 2'd3;
            state_q <= FULL;
          end
        end
        // Unused slots were zeroed on ack/clear, so FINAL pads with zeros for free.
        FULL: if (stream_ack) begin
          cnt_q   <= '0;
          data_q  <= '{default: '0};
          guard_q <= GW'(GUARD);
          state_q <= COLLECT;
        end
        FINAL: if (guard_q == '0 && hash_done_in) begin
          hash_q  <= hash_in;
          state_q <= RESULT;
        end
        RESULT: if (out_ready) begin
          clr_q   <= 1'b0;
          state_q <= CLR;
        end
        default: state_q <= CLR;
      endcase
    end
  end
endmodule

// File: tb/tb_jhash_feed.sv
// tb_jhash_feed: directed and randomized keys checked against a grouping/guard-timing model.
module tb_jhash_feed;
  localparam int G = 6;
  logic        clk = 0, rst_n = 0;
  logic [31:0] in_data = 0, hash_in = 0;
  logic        in_valid = 0, in_last = 0, in_empty = 0, stream_ack = 0, hash_done_in = 0, out_ready = 0;
  logic        in_ready, stream_valid, stream_done, core_rst, out_valid;
  logic [31:0] stream_data0, stream_data1, stream_data2, out_hash;
  logic [1:0]  stream_left;
  int cyc = 0, checks = 0, errors = 0, ack_cyc = -1000;

  jhash_feed #(.GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_empty(in_empty), .in_ready(in_ready), .stream_data0(stream_data0),
    .stream_data1(stream_data1), .stream_data2(stream_data2), .stream_valid(stream_valid),
    .stream_done(stream_done), .stream_left(stream_left), .stream_ack(stream_ack),
    .hash_in(hash_in), .hash_done_in(hash_done_in), .core_rst(core_rst),
    .out_hash(out_hash), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic e);
    int k = 0;
    @(negedge clk);
    in_data = d; in_last = l; in_empty = e; in_valid = 1;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("beat_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0; in_last = 0; in_empty = 0;
  endtask

  task automatic chk_group(input string tag, input logic [31:0] a, b, c);
    chk({tag, "_d0"}, stream_data0, a);
    chk({tag, "_d1"}, stream_data1, b);
    chk({tag, "_d2"}, stream_data2, c);
    chk({tag, "_valid"}, stream_valid, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic clr_seq(input string tag);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk({tag, "_clr_core_rst"}, core_rst, 1);
      chk({tag, "_clr_in_ready"}, in_ready, 0);
      chk({tag, "_clr_out_valid"}, out_valid, 0);
      chk({tag, "_clr_valid"}, stream_valid, 0);
    end
    @(negedge clk);
    chk({tag, "_col_core_rst"}, core_rst, 0);
    chk({tag, "_col_in_ready"}, in_ready, 1);
  endtask

  // Key of n words: groups of 3 go out as FULL unless the in_last word closes them.
  task automatic run_key(input int n, input bit eterm, input bit rnd, input int ho);
    logic [31:0] w [12];
    logic [31:0] e [3];
    logic [31:0] h;
    int nfull, base, left, hold, wt;
    bit exp_done;
    for (int i = 0; i < n; i++) w[i] = rnd ? $urandom : i + 1;
    nfull = eterm ? n / 3 : (n - 1) / 3;
    for (int g = 0; g < nfull; g++) begin
      for (int j = 0; j < 3; j++) begin
        if (rnd && $urandom_range(3) == 0) beat($urandom, 0, 1);
        beat(w[3*g+j], 0, 0);
      end
      hold = $urandom_range(3);
      for (int k = 0; k <= hold; k++) begin
        @(negedge clk);
        chk_group("full", w[3*g], w[3*g+1], w[3*g+2]);
        chk("full_done", stream_done, 0);
      end
      stream_ack = 1;
      @(posedge clk);
      #1 ack_cyc = cyc; stream_ack = 0;
      @(negedge clk);
      chk("ack_in_ready", in_ready, 1);
      chk("ack_valid", stream_valid, 0);
      if (rnd) stream_ack = 1;
      @(posedge clk);
      #1 stream_ack = 0;
    end
    base = 3 * nfull;
    left = n - base;
    for (int i = 0; i < left; i++) beat(w[base+i], !eterm && i == left - 1, 0);
    if (eterm) beat($urandom, 1, 1);
    for (int i = 0; i < 3; i++) e[i] = i < left ? w[base+i] : 0;
    h = $urandom;
    wt = $urandom_range(3);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk_group("final", e[0], e[1], e[2]);
      chk("final_left", stream_left, left);
      chk("final_out_valid", out_valid, 0);
      exp_done = (cyc - ack_cyc) >= G;
      chk("final_done", stream_done, exp_done);
      stream_ack = $urandom_range(1);
      if (exp_done && wt == 0) begin
        hash_in = h; hash_done_in = 1;
        break;
      end
      if (exp_done) wt--;
      hash_in = $urandom;
      hash_done_in = !exp_done && $urandom_range(1) == 1;
    end
    @(posedge clk);
    #1 hash_done_in = 0; stream_ack = 0; hash_in = $urandom;
    for (int k = 0; k <= ho; k++) begin
      @(negedge clk);
      chk("res_out_valid", out_valid, 1);
      chk("res_out_hash", out_hash, h);
      chk("res_in_ready", in_ready, 0);
      chk("res_core_rst", core_rst, 0);
      chk("res_valid", stream_valid, 0);
      if (k == ho) out_ready = 1;
    end
    @(posedge clk);
    #1 out_ready = 0;
    clr_seq("post");
  endtask

  initial begin
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", stream_valid, 0);
    chk("rst_done", stream_done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_hash", out_hash, 0);
    chk("rst_left", stream_left, 0);
    chk("rst_d0", stream_data0, 0);
    @(posedge clk);
    #1 rst_n = 1;
    clr_seq("init");
    run_key(3, 0, 0, 2);
    run_key(5, 0, 0, 3);
    run_key(4, 0, 0, 0);
    run_key(0, 1, 0, 1);
    run_key(3, 0, 0, 10);
    beat(7, 0, 0); beat(8, 0, 0); beat(9, 0, 0);
    @(negedge clk);
    chk("pre_rst_valid", stream_valid, 1);
    #2 rst_n = 0;
    #1;
    ack_cyc = -1000;
    chk("mid_rst_valid", stream_valid, 0);
    chk("mid_rst_core_rst", core_rst, 1);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_d0", stream_data0, 0);
    chk("mid_rst_left", stream_left, 0);
    chk("mid_rst_out_hash", out_hash, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clr_seq("mid_rst");
    run_key(2, 0, 0, 0);
    repeat (25) begin
      bit et;
      et = $urandom_range(1) == 1;
      run_key(et ? $urandom_range(10) : $urandom_range(1, 10), et, 1, $urandom_range(10));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
